mem_sequencer: RTL and testbench

Parametrised instruction-fetch and data-access sequencer for the RISC machine. It owns the program counter, the instruction register and the single shared memory port. It fetches an instruction, presents it to the decode/execute logic, then performs whatever that logic requests: next, branch, load, store or halt. Unlike the fixed-latency first-generation controller, it waits on a memory-ready handshake, supports PC loads (branches) and flags memory timeouts.

---
 rtl/mem_seq_pkg.sv | 27 ++
 rtl/mem_wait_timer.sv | 35 +++
 rtl/mem_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_mem_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_seq_pkg
// Description : Shared encodings for the instruction/data memory sequencer.
// Revision    : 1.0
// ============================================================================
package mem_seq_pkg;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    localparam logic [1:0] OP_NEXT   = 2'b00;
    localparam logic [1:0] OP_BRANCH = 2'b01;
    localparam logic [1:0] OP_LOAD   = 2'b10;
    localparam logic [1:0] OP_STORE  = 2'b11;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_LOAD   = 3'd2,
        ST_STORE  = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

endpackage : mem_seq_pkg
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : mem_wait_timer
// Description : Counts unanswered memory cycles; flags the last tolerated one.
// Revision    : 1.0
// ============================================================================
module mem_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic busy,
    input  logic ready,
    output logic expired
);

    localparam int                 c_cnt_w = $clog2(MAX_WAIT + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(MAX_WAIT - 1);

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (busy && !ready) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Fires in the MAX_WAIT-th waiting cycle; a ready in that cycle still wins.
    assign expired = busy && !ready && (r_count == c_last);

endmodule : mem_wait_timer
`default_nettype wire

// File: rtl/mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mem_sequencer
// Description : Fetch/decode/load/store sequencer owning PC, IR and memory port.
// Revision    : 1.0
// ============================================================================
module mem_sequencer
    import mem_seq_pkg::*;
#(
    parameter int                ADDR_W   = 9,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_cmd,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    input  logic              op_valid,
    input  logic [1:0]        op_kind,
    input  logic [ADDR_W-1:0] op_addr,
    input  logic [DATA_W-1:0] op_wdata,
    input  logic              halt,
    output logic [DATA_W-1:0] ld_data,
    output logic              ld_valid,
    output logic              halted,
    output logic              mem_err
);

    state_t              r_state,    w_state_nxt;
    logic [ADDR_W-1:0]   r_pc,       w_pc_nxt;
    logic [DATA_W-1:0]   r_instr,    w_instr_nxt;
    logic [ADDR_W-1:0]   r_addr,     w_addr_nxt;
    logic [DATA_W-1:0]   r_wdata,    w_wdata_nxt;
    logic [DATA_W-1:0]   r_ld_data,  w_ld_data_nxt;
    logic                r_ld_valid, w_ld_valid_nxt;
    logic                r_mem_err,  w_mem_err_nxt;
    logic                w_busy;
    logic                w_expired;

    assign w_busy = (r_state == ST_FETCH) || (r_state == ST_LOAD) || (r_state == ST_STORE);

    // Any state change restarts the count, which covers every entry into an access.
    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_state_nxt != r_state),
        .busy    (w_busy),
        .ready   (mem_ready),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_FETCH;
            r_pc       <= RESET_PC;
            r_instr    <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_ld_data  <= '0;
            r_ld_valid <= 1'b0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_instr    <= w_instr_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_ld_data  <= w_ld_data_nxt;
            r_ld_valid <= w_ld_valid_nxt;
            r_mem_err  <= w_mem_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_instr_nxt    = r_instr;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;
        w_ld_data_nxt  = r_ld_data;
        w_ld_valid_nxt = 1'b0;
        w_mem_err_nxt  = r_mem_err;
        case (r_state)
            ST_FETCH: begin
                if (mem_ready) begin
                    w_instr_nxt = read_data;
                    w_state_nxt = ST_DECODE;
                end else if (w_expired) begin
                    w_mem_err_nxt = 1'b1;
                    w_state_nxt   = ST_HALT;
                end
            end
            ST_DECODE: begin
                if (halt) begin
                    w_state_nxt = ST_HALT;
                end else if (op_valid) begin
                    case (op_kind)
                        OP_NEXT: begin
                            w_pc_nxt    = r_pc + 1'b1;
                            w_state_nxt = ST_FETCH;
                        end
                        OP_BRANCH: begin
                            w_pc_nxt    = op_addr;
                            w_state_nxt = ST_FETCH;
                        end
                        OP_LOAD: begin
                            w_addr_nxt  = op_addr;
                            w_pc_nxt    = r_pc + 1'b1;
                            w_state_nxt = ST_LOAD;
                        end
                        default: begin
                            w_addr_nxt  = op_addr;
                            w_wdata_nxt = op_wdata;
                            w_pc_nxt    = r_pc + 1'b1;
                            w_state_nxt = ST_STORE;
                        end
                    endcase
                end
            end
            ST_LOAD: begin
                if (mem_ready) begin
                    w_ld_data_nxt  = read_data;
                    w_ld_valid_nxt = 1'b1;
                    w_state_nxt    = ST_FETCH;
                end else if (w_expired) begin
                    w_mem_err_nxt = 1'b1;
                    w_state_nxt   = ST_HALT;
                end
            end
            ST_STORE: begin
                if (mem_ready) begin
                    w_state_nxt = ST_FETCH;
                end else if (w_expired) begin
                    w_mem_err_nxt = 1'b1;
                    w_state_nxt   = ST_HALT;
                end
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase
    end

    // Reset gates the port and status flags in the reset cycle itself.
    always_comb begin
        mem_cmd    = MNONE;
        mem_addr   = r_pc;
        write_data = '0;
        case (r_state)
            ST_FETCH: begin
                mem_cmd = reset ? MNONE : MREAD;
            end
            ST_LOAD: begin
                mem_cmd  = reset ? MNONE : MREAD;
                mem_addr = r_addr;
            end
            ST_STORE: begin
                mem_cmd    = reset ? MNONE : MWRITE;
                mem_addr   = r_addr;
                write_data = reset ? '0 : r_wdata;
            end
            default: begin
                mem_cmd = MNONE;
            end
        endcase
    end

    assign instr       = r_instr;
    assign pc          = r_pc;
    assign ld_data     = r_ld_data;
    assign instr_valid = !reset && (r_state == ST_DECODE);
    assign halted      = !reset && (r_state == ST_HALT);
    assign ld_valid    = !reset && r_ld_valid;
    assign mem_err     = !reset && r_mem_err;

endmodule : mem_sequencer
`default_nettype wire

// File: tb/tb_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_sequencer
// Description : Directed plus randomized bench for mem_sequencer, model based.
// Revision    : 1.0
// ============================================================================
module tb_mem_sequencer;

    localparam int ADDR_W   = 9;
    localparam int DATA_W   = 16;
    localparam int MAX_WAIT = 15;
    localparam int PC_MOD   = 1 << ADDR_W;

    localparam int P_FETCH  = 0;
    localparam int P_DECODE = 1;
    localparam int P_LOAD   = 2;
    localparam int P_STORE  = 3;
    localparam int P_HALT   = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        mem_cmd;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data = '0;
    logic              mem_ready = 1'b0;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic [ADDR_W-1:0] pc;
    logic              op_valid = 1'b0;
    logic [1:0]        op_kind = '0;
    logic [ADDR_W-1:0] op_addr = '0;
    logic [DATA_W-1:0] op_wdata = '0;
    logic              halt = 1'b0;
    logic [DATA_W-1:0] ld_data;
    logic              ld_valid;
    logic              halted;
    logic              mem_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_phase = P_FETCH;
    int m_pc = 0;
    int m_instr = 0;
    int m_addr = 0;
    int m_wdata = 0;
    int m_ld = 0;
    int m_waited = 0;
    bit m_ldv = 1'b0;
    bit m_err = 1'b0;

    always #5 clk = ~clk;

    mem_sequencer #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RESET_PC ('0),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_addr    (mem_addr),
        .mem_cmd     (mem_cmd),
        .write_data  (write_data),
        .read_data   (read_data),
        .mem_ready   (mem_ready),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .op_valid    (op_valid),
        .op_kind     (op_kind),
        .op_addr     (op_addr),
        .op_wdata    (op_wdata),
        .halt        (halt),
        .ld_data     (ld_data),
        .ld_valid    (ld_valid),
        .halted      (halted),
        .mem_err     (mem_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_access(input int ph);
        return (ph == P_FETCH) || (ph == P_LOAD) || (ph == P_STORE);
    endfunction

    // Cycle-level behaviour derived from the state descriptions.
    task automatic model_step(input bit rst, input bit rdy, input int rd, input bit opv,
                              input int kind, input int oa, input int owd, input bit hlt);
        int prev;
        prev = m_phase;
        if (rst) begin
            m_phase = P_FETCH; m_pc = 0; m_instr = 0; m_addr = 0; m_wdata = 0;
            m_ld = 0; m_ldv = 0; m_err = 0; m_waited = 0;
            return;
        end
        m_ldv = 0;
        if (is_access(m_phase)) begin
            if (rdy) begin
                if (m_phase == P_FETCH) begin
                    m_instr = rd; m_phase = P_DECODE;
                end else if (m_phase == P_LOAD) begin
                    m_ld = rd; m_ldv = 1; m_phase = P_FETCH;
                end else begin
                    m_phase = P_FETCH;
                end
            end else begin
                m_waited++;
                if (m_waited >= MAX_WAIT) begin
                    m_err = 1; m_phase = P_HALT;
                end
            end
        end else if (m_phase == P_DECODE) begin
            if (hlt) m_phase = P_HALT;
            else if (opv) begin
                if (kind == 1) m_pc = oa;
                else m_pc = (m_pc + 1) % PC_MOD;
                if (kind == 2) m_addr = oa;
                if (kind == 3) begin m_addr = oa; m_wdata = owd; end
                m_phase = (kind <= 1) ? P_FETCH : (kind == 2) ? P_LOAD : P_STORE;
            end
        end
        if (m_phase != prev) m_waited = 0;
    endtask

    task automatic cyc(input logic rst, input logic rdy, input logic [DATA_W-1:0] rd,
                       input logic opv, input logic [1:0] kind, input logic [ADDR_W-1:0] oa,
                       input logic [DATA_W-1:0] owd, input logic hlt);
        int e_cmd;
        @(posedge clk);
        #1;
        reset = rst; mem_ready = rdy; read_data = rd;
        op_valid = opv; op_kind = kind; op_addr = oa; op_wdata = owd; halt = hlt;
        @(negedge clk);
        e_cmd = rst ? 0 : (m_phase == P_FETCH || m_phase == P_LOAD) ? 1 : (m_phase == P_STORE) ? 2 : 0;
        chk("mem_cmd", 32'(mem_cmd), e_cmd);
        if (e_cmd != 0)
            chk("mem_addr", 32'(mem_addr), (m_phase == P_FETCH) ? m_pc : m_addr);
        chk("write_data", 32'(write_data), (e_cmd == 2) ? m_wdata : 0);
        chk("instr_valid", 32'(instr_valid), (!rst && m_phase == P_DECODE) ? 1 : 0);
        chk("halted", 32'(halted), (!rst && m_phase == P_HALT) ? 1 : 0);
        chk("mem_err", 32'(mem_err), (!rst && m_err) ? 1 : 0);
        chk("ld_valid", 32'(ld_valid), (!rst && m_ldv) ? 1 : 0);
        chk("ld_data", 32'(ld_data), m_ld);
        chk("instr", 32'(instr), m_instr);
        chk("pc", 32'(pc), m_pc);
        model_step(rst, rdy, int'(rd), opv, int'(kind), int'(oa), int'(owd), hlt);
    endtask

    task automatic idle(input logic rdy, input logic [DATA_W-1:0] rd);
        cyc(1'b0, rdy, rd, 1'b0, 2'd0, '0, '0, 1'b0);
    endtask

    task automatic op(input logic [1:0] kind, input logic [ADDR_W-1:0] oa, input logic [DATA_W-1:0] owd);
        cyc(1'b0, 1'b1, 16'h0, 1'b1, kind, oa, owd, 1'b0);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 16'h0, 1'b0, 2'd0, '0, '0, 1'b0);
    endtask

    initial begin
        int pct;
        do_reset();
        chk("rst_cmd", 32'(mem_cmd), 0);
        chk("rst_halted", 32'(halted), 0);
        do_reset();

        // Sequential fetches with NEXT
        for (int i = 0; i < 5; i++) begin
            idle(1'b1, 16'hA000 + 16'(i));
            chk("fetch_cmd", 32'(mem_cmd), 1);
            chk("fetch_addr", 32'(mem_addr), i);
            op(2'd0, '0, '0);
            chk("decode_valid", 32'(instr_valid), 1);
            chk("decode_instr", 32'(instr), 32'hA000 + i);
        end

        // Branch from pc 5
        idle(1'b1, 16'h5555);
        op(2'd1, 9'h1A0, '0);
        chk("branch_pc_before", 32'(pc), 5);
        idle(1'b1, 16'h1234);
        chk("branch_fetch_addr", 32'(mem_addr), 32'h1A0);
        chk("branch_pc", 32'(pc), 32'h1A0);

        // Load with three wait cycles
        op(2'd2, 9'h040, '0);
        for (int i = 0; i < 3; i++) begin
            idle(1'b0, 16'hDEAD);
            chk("load_wait_cmd", 32'(mem_cmd), 1);
            chk("load_wait_addr", 32'(mem_addr), 32'h40);
        end
        idle(1'b1, 16'hBEEF);
        chk("load_addr", 32'(mem_addr), 32'h40);
        idle(1'b1, 16'h0F0F);
        chk("ld_valid_pulse", 32'(ld_valid), 1);
        chk("ld_data_val", 32'(ld_data), 32'hBEEF);
        chk("after_load_fetch", 32'(mem_addr), 32'h1A1);

        // Store
        op(2'd3, 9'h007, 16'h1234);
        chk("ld_valid_drop", 32'(ld_valid), 0);
        idle(1'b1, 16'h0);
        chk("store_cmd", 32'(mem_cmd), 2);
        chk("store_addr", 32'(mem_addr), 7);
        chk("store_wdata", 32'(write_data), 32'h1234);
        idle(1'b1, 16'h7777);
        chk("wdata_clear", 32'(write_data), 0);

        // PC wrap
        op(2'd1, 9'h1FF, '0);
        idle(1'b1, 16'h1111);
        op(2'd0, '0, '0);
        chk("wrap_pc_before", 32'(pc), 32'h1FF);
        idle(1'b1, 16'h2222);
        chk("wrap_fetch", 32'(mem_addr), 0);

        // Halt beats op_valid
        cyc(1'b0, 1'b1, 16'h0, 1'b1, 2'd0, '0, '0, 1'b1);
        idle(1'b1, 16'h0);
        chk("halt_flag", 32'(halted), 1);
        chk("halt_pc", 32'(pc), 0);
        for (int i = 0; i < 3; i++) op(2'd1, 9'h0AA, '0);
        chk("halt_sticky", 32'(halted), 1);

        // Reset mid-load
        do_reset();
        idle(1'b1, 16'h3333);
        op(2'd2, 9'h055, '0);
        idle(1'b0, 16'h0);
        cyc(1'b1, 1'b0, 16'h0, 1'b0, 2'd0, '0, '0, 1'b0);
        chk("reset_mid_cmd", 32'(mem_cmd), 0);

        // Timeout in FETCH: 15 unanswered cycles
        for (int i = 0; i < MAX_WAIT; i++) begin
            idle(1'b0, 16'h0);
            chk("timeout_wait_cmd", 32'(mem_cmd), 1);
        end
        chk("timeout_addr", 32'(mem_addr), 0);
        idle(1'b0, 16'h0);
        chk("timeout_err", 32'(mem_err), 1);
        chk("timeout_halt", 32'(halted), 1);
        chk("timeout_cmd", 32'(mem_cmd), 0);

        // Ready in the last tolerated cycle wins
        do_reset();
        for (int i = 0; i < MAX_WAIT - 1; i++) idle(1'b0, 16'h0);
        idle(1'b1, 16'h4444);
        idle(1'b1, 16'h0);
        chk("late_ready_decode", 32'(instr_valid), 1);
        chk("late_ready_no_err", 32'(mem_err), 0);

        // Randomized traffic
        for (int seg = 0; seg < 16; seg++) begin
            case ($urandom_range(0, 3))
                0: pct = 100;
                1: pct = 70;
                2: pct = 25;
                default: pct = 5;
            endcase
            for (int k = 0; k < 200; k++) begin
                cyc(($urandom_range(0, 99) == 0),
                    ($urandom_range(1, 100) <= pct),
                    16'($urandom),
                    ($urandom_range(0, 1) == 1),
                    2'($urandom_range(0, 3)),
                    9'($urandom),
                    16'($urandom),
                    ($urandom_range(0, 39) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mem_sequencer
`default_nettype wire
